// File: rtl/slave_ram_wait.sv
// slave_ram_wait
//   Word-addressed RAM behind a level req / pulse ack slave port. Every
//   transaction is held for WAIT_CYCLES wait states and then acknowledged
//   for one cycle. Dropping slave_req during the wait states aborts the
//   transaction. An aborted write never reaches the RAM.
//
// Build option
//   SLAVE_RAM_RANGE_CHECK_EN : if defined, an address with any bit set above
//     the RAM index completes with slave_err=1. No write happens and
//     slave_rdata is 0. If not defined, the upper address bits are ignored,
//     so the address wraps, and slave_err is always 0.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (RAM contents are kept)
//   slave_req    : request, held by the master until ack
//   slave_addr   : word address
//   slave_cmd    : 1 = write, 0 = read
//   slave_wdata  : write data
//   slave_be     : byte enables, bit i covers byte i
//   slave_ack    : one-cycle completion pulse
//   slave_rdata  : read data, nonzero only while slave_ack=1
//   slave_err    : out-of-range flag, only while slave_ack=1
//
// state | meaning
// IDLE  | waiting for slave_req; request fields latched on acceptance
// WAIT  | counting down wait states; slave_req low aborts to IDLE
// ACK   | slave_ack high for this single cycle, then back to IDLE

module slave_ram_wait #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                slave_req,
   input  logic [ADDR_W-1:0]   slave_addr,
   input  logic                slave_cmd,
   input  logic [DATA_W-1:0]   slave_wdata,
   input  logic [DATA_W/8-1:0] slave_be,
   output logic                slave_ack,
   output logic [DATA_W-1:0]   slave_rdata,
   output logic                slave_err
);

   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [DEPTH_LOG2-1:0] addr_q;
   logic                  cmd_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [BE_W-1:0]       be_q;
   logic                  ack_q;
   logic [DATA_W-1:0]     rdata_q;
   logic                  err_q;

   logic [DATA_W-1:0]     mem_q [DEPTH] = '{default: '0};

   // Fields of the transaction that is current this cycle. In IDLE they come
   // straight from the port. This covers WAIT_CYCLES=0, where the request is
   // accepted and completed on the same edge. In every other state the
   // latched copy is used.
   logic                  in_idle;
   logic [DEPTH_LOG2-1:0] addr_d;
   logic                  cmd_d;
   logic [DATA_W-1:0]     wdata_d;
   logic [BE_W-1:0]       be_d;
   logic                  oor_d;
   logic                  go_ack;

   assign in_idle = (state_q == IDLE);
   assign addr_d  = in_idle ? slave_addr[DEPTH_LOG2-1:0] : addr_q;
   assign cmd_d   = in_idle ? slave_cmd   : cmd_q;
   assign wdata_d = in_idle ? slave_wdata : wdata_q;
   assign be_d    = in_idle ? slave_be    : be_q;

`ifdef SLAVE_RAM_RANGE_CHECK_EN
   logic oor_q;
   logic addr_hi_set;

   assign addr_hi_set = ((slave_addr >> DEPTH_LOG2) != '0);
   assign oor_d       = in_idle ? addr_hi_set : oor_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         oor_q <= 1'b0;
      end else if (in_idle && slave_req) begin
         oor_q <= addr_hi_set;
      end
   end
`else
   logic unused_addr_hi;

   assign unused_addr_hi = ^(slave_addr >> DEPTH_LOG2);
   assign oor_d          = 1'b0;
`endif

   // This is the edge that enters ACK. The write commits on it, and the
   // registered ack, read data and error flag are loaded on it.
   assign go_ack = ~rst & slave_req &
                   ((in_idle & (WAIT_CYCLES == 0)) |
                    ((state_q == WAIT) & (cnt_q == 4'd1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (slave_req) begin
                  addr_q  <= addr_d;
                  cmd_q   <= cmd_d;
                  wdata_q <= wdata_d;
                  be_q    <= be_d;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= ACK;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= 4'(WAIT_CYCLES);
                  end
               end
            end
            WAIT: begin
               if (!slave_req) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     state_q <= ACK;
                  end
               end
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         if (go_ack) begin
            ack_q   <= 1'b1;
            err_q   <= oor_d;
            rdata_q <= (cmd_d || oor_d) ? '0 : mem_q[addr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (go_ack && cmd_d && !oor_d) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_d[b]) begin
               mem_q[addr_d][b*8 +: 8] <= wdata_d[b*8 +: 8];
            end
         end
      end
   end

   assign slave_ack   = ack_q;
   assign slave_rdata = rdata_q;
   assign slave_err   = err_q;

endmodule
